// File: rtl/cacheline_burst_adapter_if.sv
// Signal bundle between a cache dfp port, the line/burst adapter and the memory bus.
// The slave modport is the adapter's view; master is the cache-plus-memory side.
interface cacheline_burst_adapter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BUS_W  = 64
);
    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BUS_W-1:0]  bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BUS_W-1:0]  bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Bridges a line-wide cache request to BUS_W-wide memory bursts: writes are split
// into beats from a latched line buffer, reads are assembled from tag-matched beats.
module cacheline_burst_adapter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BUS_W  = 64
) (
    input logic                      clk,
    input logic                      rst,
    cacheline_burst_adapter_if.slave bus
);
    localparam int BEATS = LINE_W / BUS_W;
    localparam int OFS   = $clog2(LINE_W / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    if ((LINE_W % BUS_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
        $error("cacheline_burst_adapter: LINE_W/BUS_W must be a power of two >= 2");
    end

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_e;

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [BEATS-1:0][BUS_W-1:0] wbuf_q, wbuf_d;
    logic [BEATS-1:0][BUS_W-1:0] rbuf_q, rbuf_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LINE_W-1:0]           dfp_rdata_q, dfp_rdata_d;
    logic                        tag_hit;
    logic                        unused_ofs_bits;

    // Beats tagged with another line (e.g. late beats of an abandoned burst) never match.
    assign tag_hit = bus.bmem_rvalid &&
                     (bus.bmem_raddr[ADDR_W-1:OFS] == addr_q[ADDR_W-1:OFS]);
    assign unused_ofs_bits = ^{bus.bmem_raddr[OFS-1:0], bus.dfp_addr[OFS-1:0]};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wbuf_d      = wbuf_q;
        rbuf_d      = rbuf_q;
        cnt_d       = cnt_q;
        dfp_rdata_d = dfp_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.dfp_read) begin
                    addr_d  = {bus.dfp_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end else if (bus.dfp_write) begin
                    addr_d  = {bus.dfp_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                    wbuf_d  = bus.dfp_wdata;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end
            end
            RD_REQ: begin
                if (bus.bmem_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (tag_hit) begin
                    rbuf_d[cnt_q] = bus.bmem_rdata;
                    cnt_d         = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        dfp_rdata_d = rbuf_d;
                        state_d     = RESP;
                    end
                end
            end
            WR_BURST: begin
                if (bus.bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wbuf_q      <= '0;
            rbuf_q      <= '0;
            cnt_q       <= '0;
            dfp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wbuf_q      <= wbuf_d;
            rbuf_q      <= rbuf_d;
            cnt_q       <= cnt_d;
            dfp_rdata_q <= dfp_rdata_d;
        end
    end

    // All outputs decode directly from registers, so none has a combinational input path.
    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_read  = (state_q == RD_REQ);
    assign bus.bmem_write = (state_q == WR_BURST);
    assign bus.bmem_wdata = (state_q == WR_BURST) ? wbuf_q[cnt_q] : '0;
    assign bus.dfp_resp   = (state_q == RESP);
    assign bus.dfp_rdata  = dfp_rdata_q;
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: a 256/64 and a 512/128 instance checked every cycle
// against a transaction-level model, plus directed literal expectations per scenario.
module tb_cacheline_burst_adapter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]  d_addr   [2];
    logic         d_read   [2];
    logic         d_write  [2];
    logic [511:0] d_wdata  [2];
    logic         d_ready  [2];
    logic [31:0]  d_raddr  [2];
    logic [127:0] d_rdata  [2];
    logic         d_rvalid [2];

    logic [511:0] o_rdata [2];
    logic         o_resp  [2];
    logic [31:0]  o_addr  [2];
    logic         o_read  [2];
    logic         o_write [2];
    logic [127:0] o_wdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LW = (g == 0) ? 256 : 512;
        localparam int BW = (g == 0) ? 64 : 128;
        cacheline_burst_adapter_if #(.ADDR_W(32), .LINE_W(LW), .BUS_W(BW)) bus ();
        cacheline_burst_adapter #(.ADDR_W(32), .LINE_W(LW), .BUS_W(BW)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign bus.dfp_addr    = d_addr[g];
        assign bus.dfp_read    = d_read[g];
        assign bus.dfp_write   = d_write[g];
        assign bus.dfp_wdata   = d_wdata[g][LW-1:0];
        assign bus.bmem_ready  = d_ready[g];
        assign bus.bmem_raddr  = d_raddr[g];
        assign bus.bmem_rdata  = d_rdata[g][BW-1:0];
        assign bus.bmem_rvalid = d_rvalid[g];
        assign o_rdata[g] = 512'(bus.dfp_rdata);
        assign o_resp[g]  = bus.dfp_resp;
        assign o_addr[g]  = bus.bmem_addr;
        assign o_read[g]  = bus.bmem_read;
        assign o_write[g] = bus.bmem_write;
        assign o_wdata[g] = 128'(bus.bmem_wdata);
    end

    localparam logic [511:0] LINE1 = {256'h0, 64'h4444444444444444, 64'h3333333333333333,
                                      64'h2222222222222222, 64'h1111111111111111};
    localparam logic [511:0] WLINE = {256'h0, 64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
                                      64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};
    localparam logic [511:0] LINE3 = {256'h0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                      64'h0F0F0F0F0F0F0F0F, 64'hA5A5A5A5A5A5A5A5};
    localparam logic [511:0] LINE4 = {256'h0, 64'h5555555555555555, 64'h6666666666666666,
                                      64'h7777777777777777, 64'h8888888888888888};
    localparam logic [511:0] LINEB = {128'hB3B3B3B3B3B3B3B3B3B3B3B3B3B3B3B3,
                                      128'hB2B2B2B2B2B2B2B2B2B2B2B2B2B2B2B2,
                                      128'hB1B1B1B1B1B1B1B1B1B1B1B1B1B1B1B1,
                                      128'hB0B0B0B0B0B0B0B0B0B0B0B0B0B0B0B0};
    localparam logic [511:0] WLINEB = {128'hC3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3,
                                       128'hC2C2C2C2C2C2C2C2C2C2C2C2C2C2C2C2,
                                       128'hC1C1C1C1C1C1C1C1C1C1C1C1C1C1C1C1,
                                       128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0};

    int n_tests = 0;
    int n_fail  = 0;

    // Model: what the adapter owes the cache and the memory, one record per instance.
    int           m_op    [2];   // 0 none, 1 read line, 2 write line
    bit           m_cmd   [2];   // read command already taken by memory
    int           m_n     [2];   // beats completed in the current line
    bit           m_resp  [2];   // completion pulse owed this cycle
    logic [511:0] m_line  [2];
    logic [511:0] m_rline [2];
    logic [31:0]  m_addr  [2];

    logic [127:0] wbeats [4];

    task automatic check(input string name, input int i, input logic [511:0] act,
                         input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h", name, i, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int i, input logic act, input logic exp);
        check(name, i, 512'(act), 512'(exp));
    endtask

    task automatic monitor();
        int bw;
        logic [511:0] bmask, lmask;
        logic [31:0] amask;
        for (int i = 0; i < 2; i++) begin
            bw    = (i == 0) ? 64 : 128;
            amask = (i == 0) ? ~32'h1F : ~32'h3F;
            bmask = (512'(1) << bw) - 512'(1);
            lmask = (i == 0) ? {256'h0, {256{1'b1}}} : {512{1'b1}};
            chk1("bmem_read", i, o_read[i], (m_op[i] == 1) && !m_cmd[i]);
            chk1("bmem_write", i, o_write[i], m_op[i] == 2);
            chk1("dfp_resp", i, o_resp[i], m_resp[i]);
            check("bmem_addr", i, 512'(o_addr[i]), 512'(m_addr[i]));
            check("dfp_rdata", i, o_rdata[i], m_rline[i]);
            if (m_op[i] == 2)
                check("bmem_wdata", i, 512'(o_wdata[i]), (m_line[i] >> (m_n[i] * bw)) & bmask);
            // advance to what the coming clock edge must produce
            if (rst) begin
                m_op[i] = 0; m_cmd[i] = 0; m_n[i] = 0; m_resp[i] = 0;
                m_line[i] = '0; m_rline[i] = '0; m_addr[i] = '0;
            end else if (m_resp[i]) begin
                m_resp[i] = 0;
            end else if (m_op[i] == 0) begin
                if (d_read[i]) begin
                    m_op[i] = 1; m_cmd[i] = 0; m_n[i] = 0; m_line[i] = '0;
                    m_addr[i] = d_addr[i] & amask;
                end else if (d_write[i]) begin
                    m_op[i] = 2; m_n[i] = 0; m_line[i] = d_wdata[i] & lmask;
                    m_addr[i] = d_addr[i] & amask;
                end
            end else if (m_op[i] == 1) begin
                if (!m_cmd[i]) begin
                    m_cmd[i] = d_ready[i];
                end else if (d_rvalid[i] && ((d_raddr[i] & amask) == m_addr[i])) begin
                    m_line[i] = m_line[i] | ((512'(d_rdata[i]) & bmask) << (m_n[i] * bw));
                    m_n[i]++;
                    if (m_n[i] == 4) begin
                        m_rline[i] = m_line[i]; m_resp[i] = 1; m_op[i] = 0;
                    end
                end
            end else if (d_ready[i]) begin
                m_n[i]++;
                if (m_n[i] == 4) begin
                    m_resp[i] = 1; m_op[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int i, input logic [31:0] addr, input logic [511:0] line,
                           input int foreign_at, input bit both);
        int bw;
        logic [511:0] bmask, lmask;
        logic [31:0] tag;
        bw    = (i == 0) ? 64 : 128;
        bmask = (512'(1) << bw) - 512'(1);
        lmask = (i == 0) ? {256'h0, {256{1'b1}}} : {512{1'b1}};
        tag   = addr & ((i == 0) ? ~32'h1F : ~32'h3F);
        d_addr[i] = addr; d_read[i] = 1'b1; d_write[i] = both; d_wdata[i] = ~line;
        tick();
        d_read[i] = 1'b0; d_write[i] = 1'b0;
        chk1("rd_cmd_t1", i, o_read[i], 1'b1);
        if (both) chk1("sim_no_write", i, o_write[i], 1'b0);
        d_ready[i] = 1'b1;
        tick();
        d_ready[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == foreign_at) begin
                d_rvalid[i] = 1'b1; d_raddr[i] = 32'h0000_2000;
                d_rdata[i] = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
                tick();
            end
            if (both) chk1("sim_no_write", i, o_write[i], 1'b0);
            d_rvalid[i] = 1'b1; d_raddr[i] = tag;
            d_rdata[i] = 128'((line >> (k * bw)) & bmask);
            tick();
        end
        d_rvalid[i] = 1'b0;
        chk1("rd_resp_pulse", i, o_resp[i], 1'b1);
        check("rd_line", i, o_rdata[i], line & lmask);
        tick();
        chk1("rd_resp_single", i, o_resp[i], 1'b0);
    endtask

    task automatic do_write(input int i, input logic [31:0] addr, input logic [511:0] line,
                            input bit alt, output int nb, output int lat);
        bit ph;
        int guard;
        d_addr[i] = addr; d_write[i] = 1'b1; d_wdata[i] = line;
        tick();
        lat = 1;
        d_write[i] = 1'b0; d_wdata[i] = ~line;
        nb = 0; ph = 1'b0; guard = 0;
        while (nb < 4 && guard < 40) begin
            d_ready[i] = alt ? ph : 1'b1;
            ph = ~ph;
            if (o_write[i] && d_ready[i]) begin
                wbeats[nb] = o_wdata[i];
                nb++;
            end
            tick();
            lat++; guard++;
        end
        d_ready[i] = 1'b0;
        chk1("wr_resp_pulse", i, o_resp[i], 1'b1);
        tick();
        chk1("wr_resp_single", i, o_resp[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, lat;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d_addr[i] = '0; d_read[i] = 0; d_write[i] = 0; d_wdata[i] = '0;
            d_ready[i] = 0; d_raddr[i] = '0; d_rdata[i] = '0; d_rvalid[i] = 0;
            m_op[i] = 0; m_cmd[i] = 0; m_n[i] = 0; m_resp[i] = 0;
            m_line[i] = '0; m_rline[i] = '0; m_addr[i] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk1("rst_read", i, o_read[i], 1'b0);
            chk1("rst_write", i, o_write[i], 1'b0);
            chk1("rst_resp", i, o_resp[i], 1'b0);
            check("rst_addr", i, 512'(o_addr[i]), 512'h0);
            check("rst_rdata", i, o_rdata[i], 512'h0);
        end
        tick();

        // default read, ideal memory
        do_read(0, 32'h0000_1234, LINE1, -1, 1'b0);
        check("t1_addr", 0, 512'(o_addr[0]), 512'(32'h0000_1220));
        check("t1_line", 0, o_rdata[0], LINE1);

        // foreign beat between the first and second beat
        do_read(0, 32'h0000_1220, LINE1, 1, 1'b0);
        check("t2_line", 0, o_rdata[0], LINE1);

        // write with alternate-cycle backpressure
        do_write(0, 32'h0000_4447, WLINE, 1'b1, nb, lat);
        check("t3_beats", 0, 512'(nb), 512'(4));
        check("t3_lat", 0, 512'(lat), 512'(9));
        check("t3_beat0", 0, 512'(wbeats[0]), 512'(64'hD0D0D0D0D0D0D0D0));
        check("t3_beat1", 0, 512'(wbeats[1]), 512'(64'hD1D1D1D1D1D1D1D1));
        check("t3_beat2", 0, 512'(wbeats[2]), 512'(64'hD2D2D2D2D2D2D2D2));
        check("t3_beat3", 0, 512'(wbeats[3]), 512'(64'hD3D3D3D3D3D3D3D3));
        check("t3_addr", 0, 512'(o_addr[0]), 512'(32'h0000_4440));
        check("t3_rdata_held", 0, o_rdata[0], LINE1);

        // simultaneous read and write request
        do_read(0, 32'h0000_3008, LINE3, -1, 1'b1);
        check("t4_addr", 0, 512'(o_addr[0]), 512'(32'h0000_3000));

        // reset after two write beats
        d_addr[0] = 32'h0000_5000; d_write[0] = 1'b1; d_wdata[0] = WLINE;
        tick();
        d_write[0] = 1'b0; d_ready[0] = 1'b1;
        tick();
        tick();
        chk1("t5_mid_burst", 0, o_write[0], 1'b1);
        rst = 1'b1; d_ready[0] = 1'b0;
        tick();
        rst = 1'b0;
        chk1("t5_read", 0, o_read[0], 1'b0);
        chk1("t5_write", 0, o_write[0], 1'b0);
        chk1("t5_resp", 0, o_resp[0], 1'b0);
        check("t5_addr", 0, 512'(o_addr[0]), 512'h0);
        check("t5_rdata", 0, o_rdata[0], 512'h0);
        check("t5_wdata", 0, 512'(o_wdata[0]), 512'h0);
        d_rvalid[0] = 1'b1; d_raddr[0] = 32'h0000_6000;
        d_rdata[0] = 128'h0000000000000000BADBADBADBADBAD0;
        repeat (3) tick();
        d_rvalid[0] = 1'b0;
        chk1("t5_stale_resp", 0, o_resp[0], 1'b0);
        check("t5_stale_rdata", 0, o_rdata[0], 512'h0);
        do_read(0, 32'h0000_6010, LINE4, -1, 1'b0);
        check("t5_line", 0, o_rdata[0], LINE4);

        // 512/128 instance
        do_read(1, 32'h0000_5A7C, LINEB, -1, 1'b0);
        check("t6_raddr", 1, 512'(o_addr[1]), 512'(32'h0000_5A40));
        check("t6_line", 1, o_rdata[1], LINEB);
        do_write(1, 32'h0000_9ABF, WLINEB, 1'b0, nb, lat);
        check("t6_beats", 1, 512'(nb), 512'(4));
        check("t6_lat", 1, 512'(lat), 512'(5));
        check("t6_waddr", 1, 512'(o_addr[1]), 512'(32'h0000_9A80));
        check("t6_beat0", 1, 512'(wbeats[0]), 512'(128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0));
        check("t6_beat3", 1, 512'(wbeats[3]), 512'(128'hC3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3));
        check("t6_rdata_held", 1, o_rdata[1], LINEB);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
